// File: rtl/mul_acc_stage_pkg.sv
// Shared definitions for the multiply-accumulate stage.
//   ST_ACCUM / ST_HOLD : FSM state codes (result pending / result presented)
//   PROD_W             : width of the signed product from the multiplier tree
//   ACC_W_DEF          : default accumulator width
//   add_ovf()          : signed-add overflow from the operand and result sign bits
package mul_pkg;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 72;

  typedef enum logic {
    S_ACCUM = ST_ACCUM,
    S_HOLD  = ST_HOLD
  } state_e;

  // Overflow happens only when both operands share a sign and the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/mul_acc_stage_add_sat.sv
// acc_add_sat: combinational ACC_W-bit signed add of the accumulator and a
// sign-extended 64-bit product, with overflow detection and optional clamp.
//   a    in  ACC_W   current accumulator (two's complement)
//   b    in  PROD_W  signed product
//   sum  out ACC_W   a + sext(b), clamped to +max/-min on overflow when SAT != 0
//   ovf  out 1       signed overflow of this add
module acc_add_sat
  import mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SAT   = 1
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] b_ext_s;
  logic [ACC_W-1:0] raw_s;

  // Sign-extend, add, and clamp toward the side the operands were heading.
  always_comb begin
    b_ext_s = ACC_W'($signed(b));
    raw_s   = a + b_ext_s;
    ovf     = add_ovf(a[ACC_W-1], b_ext_s[ACC_W-1], raw_s[ACC_W-1]);
    if (ovf && (SAT != 0)) begin
      sum = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = raw_s;
    end
  end

endmodule

// File: rtl/mul_acc_stage.sv
// mul_acc_stage: registers 64-bit signed product beats and sums them into a
// wide accumulator; presents the dot product once the beat marked last is added.
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort of the partial sum and pending beat
//   s_valid/s_ready     product beat handshake; s_prod data, s_last end-of-sum
//   m_valid/m_ready     result handshake
//   m_acc               signed accumulated sum (ACC_W bits, ACC_W >= 64)
//   m_count             terms summed, saturating at 2^CNT_W-1
//   m_ovf               sticky signed-overflow flag for the current sum
module mul_acc_stage
  import mul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = 8,
  parameter int SAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PROD_W-1:0] s_prod,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_acc,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_ovf
);

  state_e            state_r;
  logic [PROD_W-1:0] p_prod_r;
  logic              p_last_r;
  logic              p_valid_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;

  logic              consume_s;
  logic              accept_s;
  logic [ACC_W-1:0]  sum_s;
  logic              add_ovf_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  // The skid slot frees itself when its beat is consumed this cycle, so
  // s_ready depends only on registers, never on m_ready.
  assign consume_s = p_valid_r && (state_r == S_ACCUM);
  assign s_ready   = !p_valid_r || consume_s;
  assign accept_s  = s_valid && s_ready;
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  acc_add_sat #(
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_add (
    .a   (acc_r),
    .b   (p_prod_r),
    .sum (sum_s),
    .ovf (add_ovf_s)
  );

  // Input register P: loads on accept, empties on consume, dropped by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_prod_r  <= {PROD_W{1'b0}};
      p_last_r  <= 1'b0;
      p_valid_r <= 1'b0;
    end else if (clr) begin
      p_valid_r <= 1'b0;
    end else if (accept_s) begin
      p_prod_r  <= s_prod;
      p_last_r  <= s_last;
      p_valid_r <= 1'b1;
    end else if (consume_s) begin
      p_valid_r <= 1'b0;
    end
  end

  // Accumulate / hold FSM with the accumulator, term counter and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_ACCUM;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (clr) begin
      state_r <= S_ACCUM;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        S_ACCUM: begin
          if (consume_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_inc_s;
            ovf_r <= ovf_r | add_ovf_s;
            if (p_last_r) begin
              state_r <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Result taken: start the next sum from zero; a beat waiting in P
          // is consumed on the following cycle.
          if (m_ready) begin
            state_r <= S_ACCUM;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= S_ACCUM;
        end
      endcase
    end
  end

  assign m_valid = (state_r == S_HOLD);
  assign m_acc   = acc_r;
  assign m_count = cnt_r;
  assign m_ovf   = ovf_r;

endmodule

// File: tb/tb_mul_acc_stage.sv
module tb_mul_acc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        s_valid;
  logic [63:0] s_prod;
  logic        s_last;
  logic        m_ready;

  logic        s_ready_a, m_valid_a, m_ovf_a;
  logic [71:0] m_acc_a;
  logic [7:0]  m_count_a;
  logic        s_ready_b, m_valid_b, m_ovf_b;
  logic [63:0] m_acc_b;
  logic [7:0]  m_count_b;
  logic        s_ready_c, m_valid_c, m_ovf_c;
  logic [63:0] m_acc_c;
  logic [7:0]  m_count_c;

  // a: 72-bit saturating, b: 64-bit saturating, c: 64-bit wrapping
  mul_acc_stage #(.ACC_W(72), .CNT_W(8), .SAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_prod(s_prod), .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_acc(m_acc_a), .m_count(m_count_a), .m_ovf(m_ovf_a));
  mul_acc_stage #(.ACC_W(64), .CNT_W(8), .SAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_prod(s_prod), .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_acc(m_acc_b), .m_count(m_count_b), .m_ovf(m_ovf_b));
  mul_acc_stage #(.ACC_W(64), .CNT_W(8), .SAT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready_c),
    .s_prod(s_prod), .s_last(s_last), .m_valid(m_valid_c), .m_ready(m_ready),
    .m_acc(m_acc_c), .m_count(m_count_c), .m_ovf(m_ovf_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] a72;
    logic [63:0] a64s;
    logic [63:0] a64w;
    int          cnt;
    bit          o72;
    bit          o64s;
    bit          o64w;
  } exp_t;

  exp_t        exq[$];
  logic [63:0] bq_prod[$];
  bit          bq_last[$];

  logic signed [127:0] pa72, pa64s, pa64w;
  bit  po72, po64s, po64w;
  int  pcnt;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  int  hold_cnt = 0;
  int  wait_acc = 0;
  bit  counting = 0;
  bit  stall_first = 0;
  bit  chk_rdy = 0;
  bit  chk_lat = 0;
  bit  prev_mv = 0;
  logic [71:0] hold_val;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact wide sum, then clamp or wrap into a w-bit signed range.
  task automatic madd(inout logic signed [127:0] a, inout bit o, input logic [63:0] p,
                      input int w, input bit sat);
    logic signed [127:0] s, mx, mn;
    s  = a + {{64{p[63]}}, p};
    mx = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn = -mx - 128'sd1;
    if (s > mx || s < mn) begin
      o = 1'b1;
      if (sat) s = (s > mx) ? mx : mn;
      else     s = (s <<< (128 - w)) >>> (128 - w);
    end
    a = s;
  endtask

  task automatic model_clear();
    pa72 = '0; pa64s = '0; pa64w = '0;
    po72 = 1'b0; po64s = 1'b0; po64w = 1'b0;
    pcnt = 0;
  endtask

  task automatic push(input logic [63:0] p, input bit l);
    bq_prod.push_back(p);
    bq_last.push_back(l);
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, check, update model.
  // mode 0: m_ready=1, 1: random, 2: stall 5 cycles in HOLD, 3: m_ready=0
  task automatic step(input int mode);
    bit acc_hs, res_hs;
    exp_t e;
    @(negedge clk);
    clr = 1'b0;
    if (bq_prod.size() > 0) begin
      s_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_prod  = bq_prod[0];
      s_last  = bq_last[0];
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 1) == 1);
      2:       m_ready = (hold_cnt >= 5);
      default: m_ready = 1'b0;
    endcase
    #1;
    acc_hs = s_valid && s_ready_a;
    res_hs = m_valid_a && m_ready;
    if (chk_rdy && s_valid) chk("s_ready_back2back", s_ready_a, 1);
    if (chk_lat && m_valid_a && !prev_mv) chk("last_to_valid_latency", cyc - last_cyc, 2);
    if (mode == 2 && m_valid_a) begin
      if (!prev_mv) hold_val = m_acc_a;
      else chk("hold_m_acc_stable", m_acc_a, hold_val);
      hold_cnt++;
    end
    if (counting && acc_hs) wait_acc++;
    if (res_hs) begin
      chk("result_expected", exq.size() > 0, 1);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("m_acc72", m_acc_a, e.a72);
        chk("m_count72", m_count_a, e.cnt);
        chk("m_ovf72", m_ovf_a, e.o72);
        chk("m_acc64sat", m_acc_b, e.a64s);
        chk("m_ovf64sat", m_ovf_b, e.o64s);
        chk("m_acc64wrap", m_acc_c, e.a64w);
        chk("m_ovf64wrap", m_ovf_c, e.o64w);
        chk("m_valid_wrap_sync", m_valid_c, 1);
      end
      if (mode == 2 && stall_first) begin
        chk("hold_one_beat_taken", wait_acc, 1);
        stall_first = 0;
      end
      counting = 0;
      hold_cnt = 0;
    end
    if (acc_hs) begin
      madd(pa72, po72, s_prod, 72, 1'b1);
      madd(pa64s, po64s, s_prod, 64, 1'b1);
      madd(pa64w, po64w, s_prod, 64, 1'b0);
      pcnt = (pcnt < 255) ? pcnt + 1 : 255;
      if (s_last) begin
        e.a72 = pa72[71:0]; e.a64s = pa64s[63:0]; e.a64w = pa64w[63:0];
        e.cnt = pcnt; e.o72 = po72; e.o64s = po64s; e.o64w = po64w;
        exq.push_back(e);
        model_clear();
        last_cyc = cyc;
        if (!counting) begin
          counting = 1;
          wait_acc = 0;
        end
      end
      void'(bq_prod.pop_front());
      void'(bq_last.pop_front());
    end
    prev_mv = m_valid_a;
    cyc++;
  endtask

  // Mode 3 runs until a result is presented; others until all traffic drains.
  task automatic run(input int mode);
    int n = 0;
    if (mode == 3) begin
      do begin step(3); n++; end while (!prev_mv && n < 3000);
      chk("reach_hold_in_budget", prev_mv, 1);
    end else begin
      while ((bq_prod.size() > 0 || exq.size() > 0) && n < 5000) begin
        step(mode);
        n++;
      end
      chk("drain_in_budget", (bq_prod.size() == 0) && (exq.size() == 0), 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_prod = 64'd0; s_last = 1'b0; m_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", s_ready_a, 1);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_acc", m_acc_a, 0);
    chk("rst_m_count", m_count_a, 0);
    chk("rst_m_ovf", m_ovf_a, 0);

    // 1: 3, 5, -2 -> 6 / 3 / no overflow, m_valid two cycles after last accept
    push(64'd3, 1'b0); push(64'd5, 1'b0); push(-64'sd2, 1'b1);
    chk_lat = 1;
    run(3);
    chk_lat = 0;
    chk("t1_m_acc", m_acc_a, 6);
    chk("t1_m_count", m_count_a, 3);
    chk("t1_m_ovf", m_ovf_a, 0);
    run(0);

    // 2: back-to-back 4-beat sum, s_ready never drops
    repeat (2) step(0);
    for (int i = 0; i < 4; i++) push({$urandom, $urandom}, i == 3);
    chk_rdy = 1;
    run(0);
    chk_rdy = 0;

    // 3: max positive then +1
    push(64'h7fff_ffff_ffff_ffff, 1'b0); push(64'd1, 1'b1);
    run(3);
    chk("t3_sat64_acc", m_acc_b, 64'h7fff_ffff_ffff_ffff);
    chk("t3_sat64_ovf", m_ovf_b, 1);
    chk("t3_wrap64_acc", m_acc_c, 64'h8000_0000_0000_0000);
    chk("t3_wrap64_ovf", m_ovf_c, 1);
    chk("t3_acc72", m_acc_a, 72'h00_8000_0000_0000_0000);
    chk("t3_ovf72", m_ovf_a, 0);
    run(0);

    // 4: 5-cycle HOLD stall while next beats are offered
    push(64'd10, 1'b0); push(64'd20, 1'b1); push(64'd9, 1'b1); push(64'd4, 1'b1);
    stall_first = 1;
    run(2);
    chk("t4_stall_checked", stall_first, 0);

    // 5: clr after two beats, then 7 alone
    push(64'd11, 1'b0); push(64'd13, 1'b0);
    run(0);
    @(negedge clk);
    clr = 1'b1; s_valid = 1'b1; s_prod = 64'd99; s_last = 1'b1; m_ready = 1'b0;
    model_clear();
    exq.delete();
    counting = 0;
    cyc++;
    @(negedge clk);
    clr = 1'b0; s_valid = 1'b0;
    #1;
    chk("clr_m_valid", m_valid_a, 0);
    chk("clr_m_acc", m_acc_a, 0);
    chk("clr_m_count", m_count_a, 0);
    chk("clr_s_ready", s_ready_a, 1);
    prev_mv = m_valid_a;
    cyc++;
    push(64'd7, 1'b1);
    run(3);
    chk("t5_m_acc", m_acc_a, 7);
    chk("t5_m_count", m_count_a, 1);
    run(0);

    // Random sums with random handshakes
    for (int k = 0; k < 12; k++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) push({$urandom, $urandom}, i == len - 1);
        else push(64'($signed($urandom_range(0, 2000)) - 1000), i == len - 1);
      end
    end
    run(1);

    // Term counter saturation on a 260-beat sum
    for (int i = 0; i < 260; i++) push(64'($signed($urandom_range(0, 200)) - 100), i == 259);
    run(3);
    chk("cnt_saturated", m_count_a, 255);
    run(0);

    // 6: asynchronous reset while in HOLD
    push(64'd5, 1'b0); push(64'd6, 1'b1);
    run(3);
    chk("t6_in_hold", m_valid_a, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid_a, 0);
    chk("arst_m_acc", m_acc_a, 0);
    chk("arst_m_count", m_count_a, 0);
    chk("arst_m_ovf_sat", m_ovf_b, 0);
    chk("arst_s_ready", s_ready_a, 1);
    exq.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
